// File: rtl/alu_packet_deserializer_if.sv
// alu_packet_deserializer_if: serial line in, completed packet out with valid/ready handshake
interface alu_packet_deserializer_if #(parameter int N_DATA = 8);
    logic                sin;
    logic [8*N_DATA-1:0] out_data;
    logic [2:0]          out_op;
    logic [2:0]          out_err;
    logic                out_valid;
    logic                out_ready;
    logic                ovf;
    modport master (input sin, out_ready, output out_data, out_op, out_err, out_valid, ovf);
    modport slave (output sin, out_ready, input out_data, out_op, out_err, out_valid, ovf);
endinterface

// File: rtl/alu_packet_deserializer.sv
// alu_packet_deserializer: receives DATA/CMD serial frames, checks count and CRC-4, presents packets
module alu_packet_deserializer #(
    parameter int N_DATA = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input logic clk,
    input logic rst,
    alu_packet_deserializer_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, TYPE, BITS, STOP, RESYNC} state_t;
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int FW = $clog2(N_DATA + 2);
    state_t st, st_nx;
    logic [7:0] cnt, sh;
    logic [2:0] bcnt, err_nx;
    logic typ, sin_q, smp, stop_ok, stop_bad, pkt_end;
    logic [FW-1:0] fcnt;
    logic [3:0] crc, crc_dat, crc_cmd;
    logic [8*N_DATA-1:0] buff;

    function automatic logic [3:0] crc_upd(input logic [3:0] c, input logic [7:0] d, input int n);
        logic [3:0] r;
        r = c;
        for (int i = 7; i >= 8 - n; i--) r = {r[2:0], 1'b0} ^ ((r[3] ^ d[i]) ? 4'h3 : 4'h0);
        return r;
    endfunction

    always_comb begin
        st_nx = st;
        smp = cnt == 8'(CLKS_PER_BIT - 1);
        case (st)
            IDLE: st_nx = (!bus.sin && sin_q) ? (HALF == 0 ? TYPE : START) : IDLE;
            START: st_nx = cnt == 8'(HALF) ? (bus.sin ? IDLE : TYPE) : START;
            TYPE: st_nx = smp ? BITS : TYPE;
            BITS: st_nx = (smp && bcnt == 3'd7) ? STOP : BITS;
            STOP: st_nx = smp ? (bus.sin ? IDLE : RESYNC) : STOP;
            RESYNC: st_nx = bus.sin ? IDLE : RESYNC;
            default: st_nx = IDLE;
        endcase
        stop_ok = st == STOP && smp && bus.sin;
        stop_bad = st == STOP && smp && !bus.sin;
        pkt_end = stop_bad || (stop_ok && typ);
        crc_dat = crc_upd(crc, sh, 8);
        crc_cmd = crc_upd(crc, {1'b1, sh[6:4], 4'd0}, 4);
        err_nx = stop_bad ? 3'b001 : fcnt != FW'(N_DATA) ? 3'b100 : crc_cmd != sh[3:0] ? 3'b010 : 3'b000;
    end

    // cnt counts cycles since the previous bit sample; from IDLE it counts from the falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            cnt <= '0;
            sh <= '0;
            bcnt <= '0;
            typ <= 1'b0;
            sin_q <= 1'b0;
            fcnt <= '0;
            crc <= '0;
            buff <= '0;
            bus.out_data <= '0;
            bus.out_op <= '0;
            bus.out_err <= '0;
            bus.out_valid <= 1'b0;
            bus.ovf <= 1'b0;
        end else begin
            st <= st_nx;
            sin_q <= bus.sin;
            cnt <= st == IDLE ? 8'(st_nx == START) : (st_nx != st || (smp && st != START)) ? 8'd0 : cnt + 8'd1;
            if (st == TYPE && smp) typ <= bus.sin;
            if (st == BITS && smp) begin
                sh <= {sh[6:0], bus.sin};
                bcnt <= bcnt + 3'd1;
            end
            if (pkt_end) begin
                fcnt <= '0;
                crc <= '0;
                buff <= '0;
            end else if (stop_ok) begin
                buff <= (8*N_DATA)'({buff, sh});
                fcnt <= fcnt == FW'(N_DATA + 1) ? fcnt : fcnt + FW'(1);
                crc <= crc_dat;
            end
            bus.ovf <= pkt_end && bus.out_valid && !bus.out_ready;
            if (pkt_end && !(bus.out_valid && !bus.out_ready)) begin
                bus.out_valid <= 1'b1;
                bus.out_err <= err_nx;
                bus.out_data <= err_nx == 3'b000 ? buff : '0;
                bus.out_op <= err_nx == 3'b000 ? sh[6:4] : 3'b000;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_packet_deserializer.sv
// tb_alu_packet_deserializer: directed scoreboard bench, one fast-bit and one 4x-oversampled instance
module tb_alu_packet_deserializer;
    typedef struct packed {
        logic [63:0] d;
        logic [2:0]  op;
        logic [2:0]  err;
    } pkt_t;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int checks = 0;
    int errors = 0;
    int ovf_a = 0;
    int vcnt_a = 0;
    pkt_t qa[$];
    pkt_t qb[$];
    logic [63:0] d1, d2;

    always #5 clk = ~clk;

    alu_packet_deserializer_if #(.N_DATA(8)) ia ();
    alu_packet_deserializer_if #(.N_DATA(8)) ib ();
    alu_packet_deserializer #(.N_DATA(8), .CLKS_PER_BIT(1)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
    alu_packet_deserializer #(.N_DATA(8), .CLKS_PER_BIT(4)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_pkt(input string tag, input bit have, input pkt_t e,
                           input logic [63:0] d, input logic [2:0] op, input logic [2:0] err);
        chk({tag, "_pkt_expected"}, 64'(have), 64'd1);
        if (have) begin
            chk({tag, "_data"}, d, e.d);
            chk({tag, "_op"}, 64'(op), 64'(e.op));
            chk({tag, "_err"}, 64'(err), 64'(e.err));
        end
    endtask

    // Long-division CRC-4 (x^4+x+1) of {data, 1, op} with four appended zeros
    function automatic logic [3:0] ref_crc(input logic [63:0] d, input logic [2:0] op);
        logic [4:0] r;
        logic [75:0] m;
        r = '0;
        m = {d, 1'b1, op, 4'b0000};
        for (int i = 75; i >= 0; i--) begin
            r = {r[3:0], m[i]};
            if (r[4]) r = r ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    task automatic sbit(input bit s, input logic v);
        if (s) begin
            ib.sin = v;
            repeat (4) @(negedge clk);
        end else begin
            ia.sin = v;
            @(negedge clk);
        end
    endtask

    task automatic idle(input bit s, input int n);
        if (s) ib.sin = 1'b1;
        else ia.sin = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input bit s, input logic t, input logic [7:0] p, input logic stp = 1'b1);
        sbit(s, 1'b0);
        sbit(s, t);
        for (int i = 7; i >= 0; i--) sbit(s, p[i]);
        sbit(s, stp);
    endtask

    task automatic good_pkt(input bit s, input bit push, output logic [63:0] d);
        logic [2:0] op;
        d = {$urandom, $urandom};
        op = 3'($urandom);
        for (int i = 0; i < 8; i++) frame(s, 1'b0, d[63 - 8*i -: 8]);
        if (push && s) qb.push_back({d, op, 3'b000});
        if (push && !s) qa.push_back({d, op, 3'b000});
        frame(s, 1'b1, {1'b0, op, ref_crc(d, op)});
    endtask

    always @(negedge clk) begin
        pkt_t e;
        bit h;
        if (ia.ovf) ovf_a++;
        if (ia.out_valid) vcnt_a++;
        if (ia.out_valid && ia.out_ready) begin
            h = qa.size() != 0;
            e = '0;
            if (h) e = qa.pop_front();
            cmp_pkt("a", h, e, ia.out_data, ia.out_op, ia.out_err);
        end
        if (ib.out_valid && ib.out_ready) begin
            h = qb.size() != 0;
            e = '0;
            if (h) e = qb.pop_front();
            cmp_pkt("b", h, e, ib.out_data, ib.out_op, ib.out_err);
        end
    end

    initial begin
        ia.sin = 1'b1;
        ib.sin = 1'b1;
        ia.out_ready = 1'b1;
        ib.out_ready = 1'b1;
        #1 rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        chk("rst_valid", 64'(ia.out_valid), 64'd0);
        chk("rst_data", ia.out_data, 64'd0);
        chk("rst_op", 64'(ia.out_op), 64'd0);
        chk("rst_err", 64'(ia.out_err), 64'd0);
        chk("rst_ovf", 64'(ia.ovf), 64'd0);
        chk("rst_b_valid", 64'(ib.out_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle(0, 3);
        // all-zero packet with its known CRC
        vcnt_a = 0;
        repeat (8) frame(0, 1'b0, 8'h00);
        qa.push_back({64'd0, 3'd0, 3'b000});
        frame(0, 1'b1, 8'h0B);
        idle(0, 3);
        chk("valid_one_cycle", 64'(vcnt_a), 64'd1);
        repeat (8) frame(0, 1'b0, 8'h00);
        qa.push_back({64'd0, 3'd0, 3'b010});
        frame(0, 1'b1, 8'h0A);
        repeat (7) frame(0, 1'b0, 8'hA5);
        qa.push_back({64'd0, 3'd0, 3'b100});
        frame(0, 1'b1, 8'h5B);
        good_pkt(0, 1'b1, d1);
        // too many data frames, counter saturates
        repeat (10) frame(0, 1'b0, 8'h3C);
        qa.push_back({64'd0, 3'd0, 3'b100});
        frame(0, 1'b1, 8'hBB);
        idle(0, 2);
        frame(0, 1'b0, 8'h11);
        frame(0, 1'b0, 8'h22);
        qa.push_back({64'd0, 3'd0, 3'b001});
        frame(0, 1'b0, 8'h33, 1'b0);
        ia.sin = 1'b0;
        repeat (5) @(negedge clk);
        idle(0, 2);
        good_pkt(0, 1'b1, d1);
        idle(0, 4);
        // backpressure: second packet dropped with one ovf pulse
        @(posedge clk);
        #1 ia.out_ready = 1'b0;
        ovf_a = 0;
        @(negedge clk);
        good_pkt(0, 1'b1, d1);
        good_pkt(0, 1'b0, d2);
        idle(0, 4);
        chk("bp_ovf_pulses", 64'(ovf_a), 64'd1);
        chk("bp_hold_valid", 64'(ia.out_valid), 64'd1);
        chk("bp_hold_data", ia.out_data, d1);
        chk("bp_pending", 64'(qa.size()), 64'd1);
        @(posedge clk);
        #1 ia.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_drained_valid", 64'(ia.out_valid), 64'd0);
        chk("bp_queue_empty", 64'(qa.size()), 64'd0);
        // oversampled instance: short glitch is not a start bit
        ib.sin = 1'b0;
        repeat (2) @(negedge clk);
        idle(1, 60);
        chk("b_glitch_no_pkt", 64'(ib.out_valid), 64'd0);
        @(posedge clk);
        #1 ib.out_ready = 1'b0;
        @(negedge clk);
        good_pkt(1, 1'b0, d1);
        idle(1, 8);
        chk("b_held_valid", 64'(ib.out_valid), 64'd1);
        chk("b_held_data", ib.out_data, d1);
        chk("b_held_err", 64'(ib.out_err), 64'd0);
        sbit(1, 1'b0);
        sbit(1, 1'b0);
        sbit(1, 1'b1);
        sbit(1, 1'b0);
        rst_b = 1'b1;
        ib.sin = 1'b0;
        #1;
        chk("b_rst_valid", 64'(ib.out_valid), 64'd0);
        chk("b_rst_data", ib.out_data, 64'd0);
        chk("b_rst_op", 64'(ib.out_op), 64'd0);
        chk("b_rst_err", 64'(ib.out_err), 64'd0);
        chk("b_rst_ovf", 64'(ib.ovf), 64'd0);
        @(negedge clk);
        rst_b = 1'b0;
        repeat (48) @(negedge clk);
        idle(1, 60);
        chk("b_no_start_after_rst", 64'(ib.out_valid), 64'd0);
        @(posedge clk);
        #1 ib.out_ready = 1'b1;
        @(negedge clk);
        good_pkt(1, 1'b1, d2);
        idle(1, 12);
        chk("a_queue_drained", 64'(qa.size()), 64'd0);
        chk("b_queue_drained", 64'(qb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_packet_deserializer.md
ALU_PACKET_DESERIALIZER -- requirements
Module: alu_packet_deserializer

Interface
REQ-001 SHALL have parameter N_DATA, default 8, meaning number of DATA frames expected before each CMD frame (range 1..15).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 1, meaning clk cycles per serial bit (range 1..255).
REQ-003 SHALL have port clk  input  1  clock, all state updated on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sin  input  1  serial input, idle level 1.
REQ-006 SHALL have port out_data  output  8*N_DATA  received data bytes, first-received byte in MSBs.
REQ-007 SHALL have port out_op  output  3  operation code from CMD frame.
REQ-008 SHALL have port out_err  output  3  {data_err, crc_err, frame_err}, at most one bit set.
REQ-009 SHALL have port out_valid  output  1  packet available on out_data/out_op/out_err.
REQ-010 SHALL have port out_ready  input  1  consumer accepts packet.
REQ-011 SHALL have port ovf  output  1  one-cycle pulse, completed packet dropped.

Function
REQ-012 Frame format SHALL be: start bit 0, type bit (0 DATA, 1 CMD), 8 payload bits MSB first, stop bit 1.
REQ-013 CMD payload SHALL be {1'b0, OP[2:0], CRC[3:0]}; leading payload bit ignored.
REQ-014 Bit FSM SHALL have states IDLE, START, TYPE, BITS, STOP, RESYNC.
REQ-015 IDLE -> START on sin==0; START samples sin after CLKS_PER_BIT/2 (integer, min 0) cycles; sin==1 there -> IDLE (glitch, no error), else -> TYPE.
REQ-016 TYPE, each BITS bit and STOP SHALL each be sampled exactly CLKS_PER_BIT cycles after the previous sample; BITS -> STOP after 8th payload bit.
REQ-017 With CLKS_PER_BIT=1 a frame SHALL occupy exactly 11 clk cycles, and back-to-back frames (next start bit in cycle after stop bit) SHALL be received.
REQ-018 STOP sampled 0 SHALL abort the packet with frame_err and enter RESYNC; RESYNC -> IDLE on first cycle sin==1.
REQ-019 DATA frame SHALL shift payload into packet buffer and increment frame counter, counter saturating at N_DATA+1.
REQ-020 CMD frame with counter != N_DATA SHALL end packet with data_err.
REQ-021 CRC SHALL be CRC-4, polynomial x^4+x+1, init 0000, non-reflected, over bit string {all DATA payloads in reception order, 1'b1, OP[2:0]} MSB first.
REQ-022 CMD frame with counter == N_DATA and received CRC != computed CRC SHALL end packet with crc_err; match -> out_err = 000.
REQ-023 Error precedence SHALL be frame_err > data_err > crc_err; out_data and out_op SHALL be zero whenever out_err != 000.
REQ-024 Packet end SHALL reset frame counter and CRC accumulator; next frame starts a new packet.
REQ-025 out_valid SHALL assert in the cycle after the stop-bit (or failing stop-bit) sample ending the packet.
REQ-026 out_valid/out_data/out_op/out_err SHALL hold stable until a cycle with out_valid && out_ready; out_valid deasserts next cycle unless a new packet completes in that same cycle, in which case the new packet is loaded and out_valid stays 1.
REQ-027 Packet ending while out_valid==1 and out_ready==0 SHALL be discarded, output unchanged, ovf=1 for one cycle.
REQ-028 Reception SHALL continue independent of out_ready; no backpressure on sin.

Reset
REQ-029 rst SHALL immediately force FSM to IDLE, counters/buffer/CRC to 0, out_data=0, out_op=0, out_err=000, out_valid=0, ovf=0.
REQ-030 rst mid-frame or mid-packet SHALL discard all partial data; after release, reception starts only at the next 1->0 on sin observed from IDLE.

Verification
REQ-031 N_DATA=8, CLKS_PER_BIT=1: 8 DATA frames 0x00, CMD payload 0x0B (OP=000, CRC=1011), out_ready=1 -> out_valid one cycle, out_data=0, out_op=000, out_err=000.
REQ-032 Same packet, CMD payload 0x0A -> out_err=010, out_data=0, out_op=0.
REQ-033 7 DATA frames then CMD 0x0B -> out_err=100; next correct 8-frame packet -> out_err=000.
REQ-034 Stop bit forced 0 on 3rd DATA frame, sin held 0 for 5 cycles then 1 -> out_err=001, RESYNC until sin=1, next packet correct.
REQ-035 out_ready=0, two correct packets back-to-back -> first packet held, ovf pulses once at second packet end; out_ready=1 -> first packet accepted, out_valid=0.
REQ-036 CLKS_PER_BIT=4: 2-cycle low glitch on sin -> no frame; rst asserted mid-BITS -> all outputs 0, next full packet received correctly.
